// File: rtl/wave_seq_ctrl.sv
// Waveform sample scheduler: periodic tick -> ROM fetch -> registered DAC update.
// Latency: run edge E0 -> rom_en after E0+DIV+1 -> dac_strobe after E0+DIV+2+ROM_LAT.
// Backpressure: cfg port always ready out of reset; ticks landing on an in-flight fetch are dropped (overrun).
module wave_seq_ctrl #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 12,
    parameter int DIV_W   = 16,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_addr,
    input  logic [15:0]       cfg_wdata,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] dac_out,
    output logic              dac_strobe,
    output logic              busy,
    output logic              wrap,
    output logic              overrun
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FETCH, S_LATCH} state_t;

    localparam logic [2:0] LAT_LAST = 3'(ROM_LAT - 1);

    state_t            state, state_n;
    logic              run_r, oneshot_r;
    logic [DIV_W-1:0]  div_r, div_act, cnt;
    logic [ADDR_W-1:0] step_r, step_act, start_r, addr;
    logic [2:0]        lat_cnt;
    logic              clr_pend;

    logic              wr_ctrl, wr_div, wr_step, wr_start, clr_wr;
    logic              tick, tick_go, last_lat, in_flight;
    logic              wrap_now, oneshot_stop, run_nxt;
    logic [ADDR_W:0]   sum;

    assign wr_ctrl  = cfg_valid && cfg_ready && (cfg_addr == 2'd0);
    assign wr_div   = cfg_valid && cfg_ready && (cfg_addr == 2'd1);
    assign wr_step  = cfg_valid && cfg_ready && (cfg_addr == 2'd2);
    assign wr_start = cfg_valid && cfg_ready && (cfg_addr == 2'd3);
    assign clr_wr   = wr_ctrl && cfg_wdata[2];

    assign tick      = (cnt == div_act);
    assign tick_go   = tick && !clr_wr;
    assign in_flight = (state == S_FETCH) || (state == S_LATCH);
    assign last_lat  = (state == S_LATCH) && (lat_cnt == LAT_LAST);

    // A clr during the fetch keeps START in addr, so the increment and its carry are discarded.
    assign sum          = {1'b0, addr} + {1'b0, step_act};
    assign wrap_now     = last_lat && !clr_pend && !clr_wr && sum[ADDR_W];
    assign oneshot_stop = wrap_now && oneshot_r;
    assign run_nxt      = wr_ctrl ? cfg_wdata[0] : (run_r && !oneshot_stop);

    assign rom_en   = (state == S_FETCH);
    assign rom_addr = addr;
    assign busy     = (state != S_IDLE);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (run_nxt) state_n = S_WAIT;
            S_WAIT: begin
                if (!run_nxt)    state_n = S_IDLE;
                else if (tick_go) state_n = S_FETCH;
            end
            S_FETCH: state_n = S_LATCH;
            S_LATCH: if (last_lat) state_n = run_nxt ? S_WAIT : S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            cfg_ready  <= 1'b0;
            run_r      <= 1'b0;
            oneshot_r  <= 1'b0;
            div_r      <= '0;
            div_act    <= '0;
            step_r     <= ADDR_W'(1);
            step_act   <= ADDR_W'(1);
            start_r    <= '0;
            addr       <= '0;
            cnt        <= '0;
            lat_cnt    <= '0;
            clr_pend   <= 1'b0;
            dac_out    <= DATA_W'(1) << (DATA_W - 1);
            dac_strobe <= 1'b0;
            wrap       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            cfg_ready <= 1'b1;
            state     <= state_n;
            run_r     <= run_nxt;
            if (wr_ctrl)  oneshot_r <= cfg_wdata[1];
            if (wr_div)   div_r     <= cfg_wdata[DIV_W-1:0];
            if (wr_step)  step_r    <= cfg_wdata[ADDR_W-1:0];
            if (wr_start) start_r   <= cfg_wdata[ADDR_W-1:0];

            if (state == S_IDLE) begin
                cnt      <= '0;
                clr_pend <= 1'b0;
                if (state_n == S_WAIT) begin
                    addr     <= start_r;
                    div_act  <= div_r;
                    step_act <= step_r;
                end
            end else if (clr_wr) begin
                cnt  <= '0;
                addr <= start_r;
                if (in_flight && !last_lat) clr_pend <= 1'b1;
            end else begin
                // DIV/STEP shadows refresh only on a tick so a fetch in flight is unaffected.
                if (tick) begin
                    cnt     <= '0;
                    div_act <= div_r;
                    if (state == S_WAIT) step_act <= step_r;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                if (last_lat && !clr_pend) addr <= sum[ADDR_W-1:0];
            end
            if (last_lat) clr_pend <= 1'b0;

            if (state == S_FETCH)      lat_cnt <= '0;
            else if (state == S_LATCH) lat_cnt <= lat_cnt + 3'd1;

            dac_strobe <= last_lat;
            wrap       <= wrap_now;
            if (last_lat) dac_out <= rom_data;

            if (wr_ctrl)                     overrun <= 1'b0;
            else if (tick_go && in_flight)   overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// Randomised and directed bench for wave_seq_ctrl against an arithmetic sample-schedule model.
module tb_wave_seq_ctrl;
    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 12;
    localparam int DIV_W   = 16;
    localparam int ROM_LAT = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_addr;
    logic [15:0]       cfg_wdata;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] dac_out;
    logic              dac_strobe;
    logic              busy;
    logic              wrap;
    logic              overrun;

    logic [DATA_W-1:0] mem [0:2047];
    logic [DATA_W-1:0] rom_q;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wave_seq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIV_W(DIV_W), .ROM_LAT(ROM_LAT)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .dac_out(dac_out), .dac_strobe(dac_strobe), .busy(busy), .wrap(wrap), .overrun(overrun)
    );

    always @(posedge clk) if (rom_en) rom_q <= mem[rom_addr];
    assign rom_data = rom_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [15:0] d);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    // Sample k is rom[(START + k*STEP) mod 2048]; strobe k lands DIV+3+k*period cycles after the run write,
    // where period is the first multiple of DIV+1 beyond the fetch/latch window.
    task automatic run_seq(input int div, input int step_in, input int start_in, input bit oneshot, input int nstrobe);
        int  step, start, period, kmax, k, ncyc, a, last_a;
        bit  exp_ovr, es;
        step   = step_in % 2048;
        start  = start_in % 2048;
        period = div + 1;
        while (period <= ROM_LAT + 1) period += div + 1;
        exp_ovr = (div + 1) <= (ROM_LAT + 1);
        kmax = nstrobe;
        if (oneshot)
            for (int i = 0; i < nstrobe; i++)
                if (((start + i * step) % 2048) + step >= 2048) begin
                    kmax = i + 1;
                    break;
                end
        cfg_wr(2'd1, 16'(div));
        cfg_wr(2'd2, 16'(step));
        cfg_wr(2'd3, 16'(start));
        cfg_wr(2'd0, oneshot ? 16'd3 : 16'd1);
        ncyc   = div + 3 + period * (nstrobe - 1);
        k      = 0;
        last_a = start;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            es = (c >= div + 3) && (((c - div - 3) % period) == 0) && (k < kmax);
            check("strobe", dac_strobe, es);
            if (es) begin
                a = (start + k * step) % 2048;
                check("dac", dac_out, mem[a]);
                check("wrap", wrap, (a + step) >= 2048);
                if (oneshot && (a + step) >= 2048) check("busy_oneshot", busy, 0);
                last_a = a;
                k++;
            end
        end
        check("dac_hold", dac_out, mem[last_a]);
        check("overrun", overrun, exp_ovr);
        cfg_wr(2'd0, 16'd0);
        check("overrun_clr", overrun, 0);
        check("busy_stop", busy, 0);
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 2048; i++)
            mem[i] = DATA_W'($rtoi(2047.5 + 2047.0 * $sin(6.283185307 * i / 2048.0)));
        reset     = 1'b0;
        cfg_valid = 1'b0;
        cfg_addr  = 2'd0;
        cfg_wdata = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_dac", dac_out, 12'h800);
        reset = 1'b1;
        @(posedge clk); #1;
        check("cfg_ready", cfg_ready, 1);
        check("dac_mid", dac_out, 12'h800);
        check("busy0", busy, 0);
        check("overrun0", overrun, 0);
        check("rom_en0", rom_en, 0);
        check("rom_addr0", rom_addr, 0);
        check("wrap0", wrap, 0);
        check("strobe0", dac_strobe, 0);

        run_seq(3, 1, 0, 1'b0, 2049);
        run_seq(3, 12'h400, 12'h3FF, 1'b0, 5);
        run_seq(3, 12'h200, 0, 1'b1, 6);
        run_seq(0, 1, 5, 1'b0, 5);
        for (int r = 0; r < 6; r++)
            run_seq($urandom_range(0, 6), $urandom_range(0, 2047), $urandom_range(0, 2047),
                    1'($urandom_range(0, 1)), $urandom_range(2, 10));

        // Stop during the rom_en cycle: that sample still completes.
        cfg_wr(2'd1, 16'd3);
        cfg_wr(2'd2, 16'd5);
        cfg_wr(2'd3, 16'd100);
        cfg_wr(2'd0, 16'd1);
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(posedge clk); #1;
            if (rom_en) seen = 1;
        end
        check("stop_rom_en", rom_en, 1);
        check("stop_rom_addr", rom_addr, 100);
        cfg_wr(2'd0, 16'd0);
        check("stop_latch_busy", busy, 1);
        @(posedge clk); #1;
        check("stop_strobe", dac_strobe, 1);
        check("stop_dac", dac_out, mem[100]);
        check("stop_idle", busy, 0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (dac_strobe) seen = 1;
        end
        check("stop_no_more", seen, 0);

        // Reset pulse during LATCH drops the pending sample.
        cfg_wr(2'd0, 16'd1);
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(posedge clk); #1;
            if (rom_en) seen = 1;
        end
        check("rst_rom_en", rom_en, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_dac", dac_out, 12'h800);
        check("rst_mid_strobe", dac_strobe, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rom_en", rom_en, 0);
        check("rst_mid_ready", cfg_ready, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_rel_ready", cfg_ready, 1);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (dac_strobe || busy) seen = 1;
        end
        check("rst_rel_idle", seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
